dual_direction_ctrl_reg_node: RTL and testbench
===============================================

Name: dual_direction_ctrl_reg_node

Overview:
- Dual-direction pipeline node that terminates relative-addressed control packets on direction two and serves them from a parametrised control-register file plus two read-only status counters.
- Relative control packets for downstream modules are forwarded with their hop selector decremented. Absolute control packets and data packets pass through with one cycle of latency.
- Direction one, and both instruction paths, pass through a configurable-depth register pipeline.
- Sits in any PE chain slot that needs host-visible configuration registers.

Parameters:
- DATA_WIDTH, 512, forward data width; multiple of 32.
- STREAM_ID_NUM, 16, virtual streams; STREAM_ID_WIDTH = clog2.
- CHUNK_ID_NUM, 32, chunk IDs; CHUNK_ID_WIDTH = clog2; MSB = addressing mode.
- CHANNEL_ID_NUM, 1024, channels per stream; CHANNEL_ID_WIDTH = clog2.
- STATE_WIDTH, 32, state/address field width.
- INSTRUCTION_WIDTH, 2, backward instruction width. Encoding: IDLE=0, REQUEST=1, REWIND=2, RESET=3.
- INSTRUCTION_PARAMETER_WIDTH, 16, instruction parameter width.
- NUM_REGS, 16, read/write 32-bit registers; power of two, at least 2.
- REG_RESET_VALUE, 32'h0, reset and clear value of every register.
- DIR_ONE_PIPE_DEPTH, 2, direction-one and instruction-path latency in cycles; at least 1.

Ports:
- clk  in  1  single clock.
- rstn  in  1  asynchronous active-low reset.
- dirOneFront_{Data,Type,Last,StreamID,ChunkID,ChannelID,State}  in  bus widths  direction-one forward input.
- dirOneBack_{Data,Type,Last,StreamID,ChunkID,ChannelID,State}  out  bus widths  direction-one forward output.
- dirOneBack_Instruction{Type,StreamID,ChannelID,Parameter}  in  instruction widths  direction-one instructions arriving from downstream.
- dirOneFront_Instruction{Type,StreamID,ChannelID,Parameter}  out  instruction widths  direction-one instructions sent upstream.
- dirTwoFront_{Data,Type,Last,StreamID,ChunkID,ChannelID,State}  in  bus widths  direction-two input.
- dirTwoBack_{Data,Type,Last,StreamID,ChunkID,ChannelID,State}  out  bus widths  direction-two output.
- dirTwoBack_Instruction{Type,StreamID,ChannelID,Parameter}  in  instruction widths  direction-two instructions in.
- dirTwoFront_Instruction{Type,StreamID,ChannelID,Parameter}  out  instruction widths  direction-two instructions out.
- ctrl_regs  out  32*NUM_REGS  flat register file; register i is at bits [32i+31:32i].

Behaviour:
- Reset (rstn low, asynchronous):
  - All Type outputs = 0; all InstructionType outputs = IDLE.
  - Every other output and every pipeline stage = 0.
  - Registers = REG_RESET_VALUE; both counters = 0.
  - Reset asserted mid-packet discards all in-flight beats; nothing is replayed.
- Type decoding: Type[1] = control, Type[0] = data. 2'b11 is handled as control only. 2'b00 is idle.
- Direction two: fixed one-cycle latency. Output registers are updated every cycle; idle input produces Type = 0.
- Relative control (ChunkID MSB = 1), ChannelID != 0:
  - Forward all fields unchanged except ChannelID = input ChannelID - 1.
- Relative control, ChannelID == 0: the packet is consumed. Its output slot carries either the read response or idle, never the request itself. consumed_cnt increments by 1, wrapping at 2^32.
  - Opcode = ChunkID[CHUNK_ID_WIDTH-2:0]; A = State.
  - Opcode 0, READ_REQUEST, produces a response in the next cycle:
    - Type = 2'b10; ChunkID = {0, 1} (CTRL_READ_RESPONSE_32b); Last = 1.
    - StreamID and ChannelID copied from the request; State = A.
    - Data = read value replicated into every 32-bit field.
    - Read value: A < NUM_REGS returns reg[A]; A == NUM_REGS returns data_cnt; A == NUM_REGS+1 returns consumed_cnt (pre-increment value); any other A returns 0.
  - Opcode 1, WRITE: if A < NUM_REGS, reg[A] <= Data[31:0]; any other A is ignored. Output slot is idle.
  - Any other opcode: dropped, output idle; consumed_cnt still increments.
- Absolute control (MSB = 0) and data packets: forwarded intact.
  - data_cnt increments on each Type == 2'b01 beat, wrapping at 2^32.
- Read after write: a read in cycle t+1 of a register written by the beat in cycle t returns the new value.
- ctrl_regs reflects a write on the clock edge that accepts the write beat.
- Instruction paths:
  - Each direction's instruction fields are delayed DIR_ONE_PIPE_DEPTH cycles: dirXBack_Instruction* to dirXFront_Instruction*.
  - A dirTwoBack_InstructionType == RESET clears registers and both counters on the edge that samples it, and is still forwarded.
  - If RESET and a WRITE arrive in the same cycle, RESET wins and the write is lost.
- Direction one: all seven fields delayed DIR_ONE_PIPE_DEPTH cycles; no modification and no inspection.

Test Plan:
- Write: relative WRITE, ChannelID=0, State=3, Data[31:0]=0xCAFEF00D -> ctrl_regs[127:96]=0xCAFEF00D next edge; dirTwoBack_Type=0 that cycle. Follow with READ of State=3 in the next cycle -> response Type=2'b10, ChunkID=1, State=3, every 32-bit field 0xCAFEF00D, Last=1.
- Hop forwarding: relative READ with ChannelID=5 -> forwarded one cycle later with ChannelID=4; registers and consumed_cnt unchanged.
- Counters: 7 data beats, then READ of State=16 (NUM_REGS=16) -> response Data=7. Then READ of State=17 -> response Data=1. Then READ of State=40 -> response Data=0.
- RESET instruction: write reg5=0x55, then dirTwoBack_InstructionType=RESET together with a WRITE to reg5 -> reg5=0 and counters=0. dirTwoFront_InstructionType=RESET exactly DIR_ONE_PIPE_DEPTH cycles later.
- Passthrough: absolute EOS packet and a dirOne beat with DIR_ONE_PIPE_DEPTH=3 -> EOS unchanged after 1 cycle; dirOne beat identical after 3 cycles.
- Asynchronous reset: drop rstn mid-burst, off any clock edge -> Type outputs 0 and InstructionType IDLE immediately; after release, ctrl_regs all equal REG_RESET_VALUE.

Source files
------------

// File: rtl/dual_direction_ctrl_reg_node_if.sv
`default_nettype none
// ============================================================================
// Module   : dual_direction_ctrl_reg_node_if
// Purpose  : Bundles every bus and instruction signal of the dual-direction
//            control-register node.
// Modports : master - the upstream/downstream environment (drives Front data
//                     and Back instructions, observes the rest)
//            slave  - the node itself
// Signals  : dirOne{Front,Back}_*            direction-one forward bus
//            dirOne{Back,Front}_Instruction* direction-one instruction path
//            dirTwo{Front,Back}_*            direction-two forward bus
//            dirTwo{Back,Front}_Instruction* direction-two instruction path
// Revision : 1.0 - initial release
// ============================================================================
interface dual_direction_ctrl_reg_node_if #(
  parameter int DATA_WIDTH                  = 512,
  parameter int STREAM_ID_NUM               = 16,
  parameter int CHUNK_ID_NUM                = 32,
  parameter int CHANNEL_ID_NUM              = 1024,
  parameter int STATE_WIDTH                 = 32,
  parameter int INSTRUCTION_WIDTH           = 2,
  parameter int INSTRUCTION_PARAMETER_WIDTH = 16
) ();
  localparam int c_SID_W = $clog2(STREAM_ID_NUM);
  localparam int c_CKID_W = $clog2(CHUNK_ID_NUM);
  localparam int c_CHID_W = $clog2(CHANNEL_ID_NUM);

  // Direction one forward bus
  logic [DATA_WIDTH-1:0]  dirOneFront_Data;
  logic [1:0]             dirOneFront_Type;
  logic                   dirOneFront_Last;
  logic [c_SID_W-1:0]     dirOneFront_StreamID;
  logic [c_CKID_W-1:0]    dirOneFront_ChunkID;
  logic [c_CHID_W-1:0]    dirOneFront_ChannelID;
  logic [STATE_WIDTH-1:0] dirOneFront_State;
  logic [DATA_WIDTH-1:0]  dirOneBack_Data;
  logic [1:0]             dirOneBack_Type;
  logic                   dirOneBack_Last;
  logic [c_SID_W-1:0]     dirOneBack_StreamID;
  logic [c_CKID_W-1:0]    dirOneBack_ChunkID;
  logic [c_CHID_W-1:0]    dirOneBack_ChannelID;
  logic [STATE_WIDTH-1:0] dirOneBack_State;

  // Direction one instruction path
  logic [INSTRUCTION_WIDTH-1:0]           dirOneBack_InstructionType;
  logic [c_SID_W-1:0]                     dirOneBack_InstructionStreamID;
  logic [c_CHID_W-1:0]                    dirOneBack_InstructionChannelID;
  logic [INSTRUCTION_PARAMETER_WIDTH-1:0] dirOneBack_InstructionParameter;
  logic [INSTRUCTION_WIDTH-1:0]           dirOneFront_InstructionType;
  logic [c_SID_W-1:0]                     dirOneFront_InstructionStreamID;
  logic [c_CHID_W-1:0]                    dirOneFront_InstructionChannelID;
  logic [INSTRUCTION_PARAMETER_WIDTH-1:0] dirOneFront_InstructionParameter;

  // Direction two forward bus
  logic [DATA_WIDTH-1:0]  dirTwoFront_Data;
  logic [1:0]             dirTwoFront_Type;
  logic                   dirTwoFront_Last;
  logic [c_SID_W-1:0]     dirTwoFront_StreamID;
  logic [c_CKID_W-1:0]    dirTwoFront_ChunkID;
  logic [c_CHID_W-1:0]    dirTwoFront_ChannelID;
  logic [STATE_WIDTH-1:0] dirTwoFront_State;
  logic [DATA_WIDTH-1:0]  dirTwoBack_Data;
  logic [1:0]             dirTwoBack_Type;
  logic                   dirTwoBack_Last;
  logic [c_SID_W-1:0]     dirTwoBack_StreamID;
  logic [c_CKID_W-1:0]    dirTwoBack_ChunkID;
  logic [c_CHID_W-1:0]    dirTwoBack_ChannelID;
  logic [STATE_WIDTH-1:0] dirTwoBack_State;

  // Direction two instruction path
  logic [INSTRUCTION_WIDTH-1:0]           dirTwoBack_InstructionType;
  logic [c_SID_W-1:0]                     dirTwoBack_InstructionStreamID;
  logic [c_CHID_W-1:0]                    dirTwoBack_InstructionChannelID;
  logic [INSTRUCTION_PARAMETER_WIDTH-1:0] dirTwoBack_InstructionParameter;
  logic [INSTRUCTION_WIDTH-1:0]           dirTwoFront_InstructionType;
  logic [c_SID_W-1:0]                     dirTwoFront_InstructionStreamID;
  logic [c_CHID_W-1:0]                    dirTwoFront_InstructionChannelID;
  logic [INSTRUCTION_PARAMETER_WIDTH-1:0] dirTwoFront_InstructionParameter;

  modport master (
    output dirOneFront_Data, dirOneFront_Type, dirOneFront_Last, dirOneFront_StreamID,
           dirOneFront_ChunkID, dirOneFront_ChannelID, dirOneFront_State,
           dirOneBack_InstructionType, dirOneBack_InstructionStreamID,
           dirOneBack_InstructionChannelID, dirOneBack_InstructionParameter,
           dirTwoFront_Data, dirTwoFront_Type, dirTwoFront_Last, dirTwoFront_StreamID,
           dirTwoFront_ChunkID, dirTwoFront_ChannelID, dirTwoFront_State,
           dirTwoBack_InstructionType, dirTwoBack_InstructionStreamID,
           dirTwoBack_InstructionChannelID, dirTwoBack_InstructionParameter,
    input  dirOneBack_Data, dirOneBack_Type, dirOneBack_Last, dirOneBack_StreamID,
           dirOneBack_ChunkID, dirOneBack_ChannelID, dirOneBack_State,
           dirOneFront_InstructionType, dirOneFront_InstructionStreamID,
           dirOneFront_InstructionChannelID, dirOneFront_InstructionParameter,
           dirTwoBack_Data, dirTwoBack_Type, dirTwoBack_Last, dirTwoBack_StreamID,
           dirTwoBack_ChunkID, dirTwoBack_ChannelID, dirTwoBack_State,
           dirTwoFront_InstructionType, dirTwoFront_InstructionStreamID,
           dirTwoFront_InstructionChannelID, dirTwoFront_InstructionParameter
  );

  modport slave (
    input  dirOneFront_Data, dirOneFront_Type, dirOneFront_Last, dirOneFront_StreamID,
           dirOneFront_ChunkID, dirOneFront_ChannelID, dirOneFront_State,
           dirOneBack_InstructionType, dirOneBack_InstructionStreamID,
           dirOneBack_InstructionChannelID, dirOneBack_InstructionParameter,
           dirTwoFront_Data, dirTwoFront_Type, dirTwoFront_Last, dirTwoFront_StreamID,
           dirTwoFront_ChunkID, dirTwoFront_ChannelID, dirTwoFront_State,
           dirTwoBack_InstructionType, dirTwoBack_InstructionStreamID,
           dirTwoBack_InstructionChannelID, dirTwoBack_InstructionParameter,
    output dirOneBack_Data, dirOneBack_Type, dirOneBack_Last, dirOneBack_StreamID,
           dirOneBack_ChunkID, dirOneBack_ChannelID, dirOneBack_State,
           dirOneFront_InstructionType, dirOneFront_InstructionStreamID,
           dirOneFront_InstructionChannelID, dirOneFront_InstructionParameter,
           dirTwoBack_Data, dirTwoBack_Type, dirTwoBack_Last, dirTwoBack_StreamID,
           dirTwoBack_ChunkID, dirTwoBack_ChannelID, dirTwoBack_State,
           dirTwoFront_InstructionType, dirTwoFront_InstructionStreamID,
           dirTwoFront_InstructionChannelID, dirTwoFront_InstructionParameter
  );
endinterface
`default_nettype wire

// File: rtl/dual_direction_ctrl_reg_node.sv
`default_nettype none
// ============================================================================
// Module   : dual_direction_ctrl_reg_node
// Purpose  : Pipeline node that terminates hop-zero relative control packets
//            on direction two and serves them from a register file plus two
//            read-only counters (data beats seen, control packets consumed).
//            Other relative control packets are forwarded with the hop
//            selector (ChannelID) decremented; everything else on direction
//            two passes with one cycle of latency. Direction one and both
//            instruction paths are plain DIR_ONE_PIPE_DEPTH-stage delays.
// Ports    : clk       - clock
//            rstn      - asynchronous active-low reset
//            bus       - slave side of the node interface (both directions)
//            ctrl_regs - flat register file, reg i at [32i+31:32i]
// Revision : 1.0 - initial release
// ============================================================================
module dual_direction_ctrl_reg_node #(
  parameter int          DATA_WIDTH                  = 512,
  parameter int          STREAM_ID_NUM               = 16,
  parameter int          CHUNK_ID_NUM                = 32,
  parameter int          CHANNEL_ID_NUM              = 1024,
  parameter int          STATE_WIDTH                 = 32,
  parameter int          INSTRUCTION_WIDTH           = 2,
  parameter int          INSTRUCTION_PARAMETER_WIDTH = 16,
  parameter int          NUM_REGS                    = 16,
  parameter logic [31:0] REG_RESET_VALUE             = 32'h0,
  parameter int          DIR_ONE_PIPE_DEPTH          = 2
) (
  input  wire logic                    clk,
  input  wire logic                    rstn,
  dual_direction_ctrl_reg_node_if.slave bus,
  output logic [32*NUM_REGS-1:0]       ctrl_regs
);
  localparam int c_SID_W   = $clog2(STREAM_ID_NUM);
  localparam int c_CKID_W  = $clog2(CHUNK_ID_NUM);
  localparam int c_CHID_W  = $clog2(CHANNEL_ID_NUM);
  localparam int c_REG_IDX_W = $clog2(NUM_REGS);

  localparam logic [INSTRUCTION_WIDTH-1:0] c_INSTR_RESET = INSTRUCTION_WIDTH'(3);
  localparam logic [c_CKID_W-2:0]          c_OP_READ     = '0;
  localparam logic [c_CKID_W-2:0]          c_OP_WRITE    = (c_CKID_W-1)'(1);
  localparam logic [c_CKID_W-1:0]          c_CHUNK_RESP  = c_CKID_W'(1);
  localparam logic [STATE_WIDTH-1:0]       c_DCNT_ADDR   = STATE_WIDTH'(NUM_REGS);
  localparam logic [STATE_WIDTH-1:0]       c_CCNT_ADDR   = STATE_WIDTH'(NUM_REGS + 1);

  // Packed widths of one direction-one beat and one instruction word
  localparam int c_BEAT_W  = DATA_WIDTH + 2 + 1 + c_SID_W + c_CKID_W + c_CHID_W + STATE_WIDTH;
  localparam int c_INSTR_W = INSTRUCTION_WIDTH + c_SID_W + c_CHID_W + INSTRUCTION_PARAMETER_WIDTH;

  // --------------------------------------------------------------------------
  // Direction one and instruction delay lines
  // --------------------------------------------------------------------------
  logic [c_BEAT_W-1:0]  r_d1Pipe [DIR_ONE_PIPE_DEPTH];
  logic [c_INSTR_W-1:0] r_i1Pipe [DIR_ONE_PIPE_DEPTH];
  logic [c_INSTR_W-1:0] r_i2Pipe [DIR_ONE_PIPE_DEPTH];
  logic [c_BEAT_W-1:0]  w_d1In;
  logic [c_INSTR_W-1:0] w_i1In;
  logic [c_INSTR_W-1:0] w_i2In;

  assign w_d1In = {bus.dirOneFront_Data, bus.dirOneFront_Type, bus.dirOneFront_Last,
                   bus.dirOneFront_StreamID, bus.dirOneFront_ChunkID,
                   bus.dirOneFront_ChannelID, bus.dirOneFront_State};
  assign w_i1In = {bus.dirOneBack_InstructionType, bus.dirOneBack_InstructionStreamID,
                   bus.dirOneBack_InstructionChannelID, bus.dirOneBack_InstructionParameter};
  assign w_i2In = {bus.dirTwoBack_InstructionType, bus.dirTwoBack_InstructionStreamID,
                   bus.dirTwoBack_InstructionChannelID, bus.dirTwoBack_InstructionParameter};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DIR_ONE_PIPE_DEPTH; i++) begin
        r_d1Pipe[i] <= '0;
        r_i1Pipe[i] <= '0;
        r_i2Pipe[i] <= '0;
      end
    end else begin
      r_d1Pipe[0] <= w_d1In;
      r_i1Pipe[0] <= w_i1In;
      r_i2Pipe[0] <= w_i2In;
      for (int i = 1; i < DIR_ONE_PIPE_DEPTH; i++) begin
        r_d1Pipe[i] <= r_d1Pipe[i-1];
        r_i1Pipe[i] <= r_i1Pipe[i-1];
        r_i2Pipe[i] <= r_i2Pipe[i-1];
      end
    end
  end

  assign {bus.dirOneBack_Data, bus.dirOneBack_Type, bus.dirOneBack_Last,
          bus.dirOneBack_StreamID, bus.dirOneBack_ChunkID,
          bus.dirOneBack_ChannelID, bus.dirOneBack_State} = r_d1Pipe[DIR_ONE_PIPE_DEPTH-1];
  assign {bus.dirOneFront_InstructionType, bus.dirOneFront_InstructionStreamID,
          bus.dirOneFront_InstructionChannelID,
          bus.dirOneFront_InstructionParameter} = r_i1Pipe[DIR_ONE_PIPE_DEPTH-1];
  assign {bus.dirTwoFront_InstructionType, bus.dirTwoFront_InstructionStreamID,
          bus.dirTwoFront_InstructionChannelID,
          bus.dirTwoFront_InstructionParameter} = r_i2Pipe[DIR_ONE_PIPE_DEPTH-1];

  // --------------------------------------------------------------------------
  // Direction two decode
  // --------------------------------------------------------------------------
  logic                   w_isCtrl;
  logic                   w_isData;
  logic                   w_isRel;
  logic                   w_consume;
  logic [c_CKID_W-2:0]    w_opcode;
  logic [STATE_WIDTH-1:0] w_addr;
  logic                   w_addrInRange;
  logic [c_REG_IDX_W-1:0] w_regIdx;
  logic                   w_wrEn;
  logic                   w_instrReset;

  // Type[1] takes precedence, so 2'b11 is treated as control
  assign w_isCtrl      = bus.dirTwoFront_Type[1];
  assign w_isData      = (bus.dirTwoFront_Type == 2'b01);
  assign w_isRel       = w_isCtrl && bus.dirTwoFront_ChunkID[c_CKID_W-1];
  assign w_consume     = w_isRel && (bus.dirTwoFront_ChannelID == '0);
  assign w_opcode      = bus.dirTwoFront_ChunkID[c_CKID_W-2:0];
  assign w_addr        = bus.dirTwoFront_State;
  assign w_addrInRange = (w_addr < c_DCNT_ADDR);
  assign w_regIdx      = w_addr[c_REG_IDX_W-1:0];
  assign w_wrEn        = w_consume && (w_opcode == c_OP_WRITE) && w_addrInRange;
  assign w_instrReset  = (bus.dirTwoBack_InstructionType == c_INSTR_RESET);

  // --------------------------------------------------------------------------
  // Register file and counters
  // --------------------------------------------------------------------------
  logic [31:0] r_regs [NUM_REGS];
  logic [31:0] r_dataCnt;
  logic [31:0] r_consumedCnt;

  // The RESET instruction outranks a same-cycle write
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= REG_RESET_VALUE;
    end else if (w_instrReset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= REG_RESET_VALUE;
    end else if (w_wrEn) begin
      r_regs[w_regIdx] <= bus.dirTwoFront_Data[31:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dataCnt     <= '0;
      r_consumedCnt <= '0;
    end else if (w_instrReset) begin
      r_dataCnt     <= '0;
      r_consumedCnt <= '0;
    end else begin
      if (w_isData)  r_dataCnt     <= r_dataCnt + 32'd1;
      if (w_consume) r_consumedCnt <= r_consumedCnt + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_ctrlRegs
    assign ctrl_regs[32*g +: 32] = r_regs[g];
  end

  // Register writes land on the edge, so a read in the following cycle
  // already sees the new contents without any bypass path.
  logic [31:0] w_rdVal;
  always_comb begin
    w_rdVal = '0;
    if (w_addrInRange)              w_rdVal = r_regs[w_regIdx];
    else if (w_addr == c_DCNT_ADDR) w_rdVal = r_dataCnt;
    else if (w_addr == c_CCNT_ADDR) w_rdVal = r_consumedCnt;
  end

  // --------------------------------------------------------------------------
  // Direction two output stage
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]  w_nData;
  logic [1:0]             w_nType;
  logic                   w_nLast;
  logic [c_SID_W-1:0]     w_nStreamID;
  logic [c_CKID_W-1:0]    w_nChunkID;
  logic [c_CHID_W-1:0]    w_nChannelID;
  logic [STATE_WIDTH-1:0] w_nState;

  always_comb begin
    w_nData      = bus.dirTwoFront_Data;
    w_nType      = bus.dirTwoFront_Type;
    w_nLast      = bus.dirTwoFront_Last;
    w_nStreamID  = bus.dirTwoFront_StreamID;
    w_nChunkID   = bus.dirTwoFront_ChunkID;
    w_nChannelID = bus.dirTwoFront_ChannelID;
    w_nState     = bus.dirTwoFront_State;
    if (w_consume) begin
      // Consumed request: slot becomes idle unless it turns into a response
      w_nData      = '0;
      w_nType      = 2'b00;
      w_nLast      = 1'b0;
      w_nStreamID  = '0;
      w_nChunkID   = '0;
      w_nChannelID = '0;
      w_nState     = '0;
      if (w_opcode == c_OP_READ) begin
        w_nData      = {(DATA_WIDTH/32){w_rdVal}};
        w_nType      = 2'b10;
        w_nLast      = 1'b1;
        w_nStreamID  = bus.dirTwoFront_StreamID;
        w_nChunkID   = c_CHUNK_RESP;
        w_nChannelID = bus.dirTwoFront_ChannelID;
        w_nState     = w_addr;
      end
    end else if (w_isRel) begin
      w_nChannelID = bus.dirTwoFront_ChannelID - c_CHID_W'(1);
    end
  end

  logic [DATA_WIDTH-1:0]  r_d2Data;
  logic [1:0]             r_d2Type;
  logic                   r_d2Last;
  logic [c_SID_W-1:0]     r_d2StreamID;
  logic [c_CKID_W-1:0]    r_d2ChunkID;
  logic [c_CHID_W-1:0]    r_d2ChannelID;
  logic [STATE_WIDTH-1:0] r_d2State;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_d2Data      <= '0;
      r_d2Type      <= 2'b00;
      r_d2Last      <= 1'b0;
      r_d2StreamID  <= '0;
      r_d2ChunkID   <= '0;
      r_d2ChannelID <= '0;
      r_d2State     <= '0;
    end else begin
      r_d2Data      <= w_nData;
      r_d2Type      <= w_nType;
      r_d2Last      <= w_nLast;
      r_d2StreamID  <= w_nStreamID;
      r_d2ChunkID   <= w_nChunkID;
      r_d2ChannelID <= w_nChannelID;
      r_d2State     <= w_nState;
    end
  end

  assign bus.dirTwoBack_Data      = r_d2Data;
  assign bus.dirTwoBack_Type      = r_d2Type;
  assign bus.dirTwoBack_Last      = r_d2Last;
  assign bus.dirTwoBack_StreamID  = r_d2StreamID;
  assign bus.dirTwoBack_ChunkID   = r_d2ChunkID;
  assign bus.dirTwoBack_ChannelID = r_d2ChannelID;
  assign bus.dirTwoBack_State     = r_d2State;

endmodule
`default_nettype wire

// File: tb/tb_dual_direction_ctrl_reg_node.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_direction_ctrl_reg_node
// Purpose  : Directed self-checking bench for dual_direction_ctrl_reg_node
//            (defaults, DIR_ONE_PIPE_DEPTH = 3). Inputs are driven and outputs
//            sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_direction_ctrl_reg_node;
  localparam int c_DEPTH = 3;

  logic clk;
  logic rstn;
  logic [32*16-1:0] ctrl_regs;
  int checks;
  int errors;

  dual_direction_ctrl_reg_node_if bus ();

  dual_direction_ctrl_reg_node #(
    .DIR_ONE_PIPE_DEPTH(c_DEPTH)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .ctrl_regs(ctrl_regs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Relative chunk IDs: MSB set, low bits = opcode
  localparam logic [4:0] c_REL_READ  = 5'b10000;
  localparam logic [4:0] c_REL_WRITE = 5'b10001;
  localparam logic [4:0] c_REL_OP2   = 5'b10010;

  task automatic drv2(input logic [1:0] t, input logic [4:0] ck, input logic [9:0] ch,
                      input logic [31:0] st, input logic [511:0] d, input logic [3:0] sid,
                      input logic l);
    bus.dirTwoFront_Type      = t;
    bus.dirTwoFront_ChunkID   = ck;
    bus.dirTwoFront_ChannelID = ch;
    bus.dirTwoFront_State     = st;
    bus.dirTwoFront_Data      = d;
    bus.dirTwoFront_StreamID  = sid;
    bus.dirTwoFront_Last      = l;
  endtask

  task automatic idle_all();
    drv2(2'b00, '0, '0, '0, '0, '0, 1'b0);
    bus.dirOneFront_Type = 2'b00; bus.dirOneFront_Data = '0; bus.dirOneFront_Last = 1'b0;
    bus.dirOneFront_StreamID = '0; bus.dirOneFront_ChunkID = '0;
    bus.dirOneFront_ChannelID = '0; bus.dirOneFront_State = '0;
    bus.dirOneBack_InstructionType = '0; bus.dirOneBack_InstructionStreamID = '0;
    bus.dirOneBack_InstructionChannelID = '0; bus.dirOneBack_InstructionParameter = '0;
    bus.dirTwoBack_InstructionType = '0; bus.dirTwoBack_InstructionStreamID = '0;
    bus.dirTwoBack_InstructionChannelID = '0; bus.dirTwoBack_InstructionParameter = '0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle_all();
    @(negedge clk);
    checks++; if (bus.dirTwoBack_Type !== 2'b00) begin errors++; $display("FAIL reset_d2type: got %0d want 0", bus.dirTwoBack_Type); end
    checks++; if (bus.dirOneBack_Type !== 2'b00) begin errors++; $display("FAIL reset_d1type: got %0d want 0", bus.dirOneBack_Type); end
    checks++; if (bus.dirTwoFront_InstructionType !== 2'b00 || bus.dirOneFront_InstructionType !== 2'b00) begin
      errors++; $display("FAIL reset_instr: got %0d/%0d want 0/0", bus.dirOneFront_InstructionType, bus.dirTwoFront_InstructionType); end
    checks++; if (ctrl_regs !== '0) begin errors++; $display("FAIL reset_regs: got %h want 0", ctrl_regs); end
    checks++; if (bus.dirTwoBack_Data !== '0) begin errors++; $display("FAIL reset_d2data: got %h want 0", bus.dirTwoBack_Data); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [511:0] exp;
    exp = {16{32'hCAFEF00D}};
    drv2(2'b10, c_REL_WRITE, 10'd0, 32'd3, {480'd0, 32'hCAFEF00D}, 4'd2, 1'b1);
    @(negedge clk);
    checks++; if (ctrl_regs[127:96] !== 32'hCAFEF00D) begin errors++; $display("FAIL wr_reg3: got %h want cafef00d", ctrl_regs[127:96]); end
    checks++; if (bus.dirTwoBack_Type !== 2'b00) begin errors++; $display("FAIL wr_idle: got %0d want 0", bus.dirTwoBack_Type); end
    drv2(2'b10, c_REL_READ, 10'd0, 32'd3, '0, 4'd7, 1'b0);
    @(negedge clk);
    checks++; if (bus.dirTwoBack_Type !== 2'b10) begin errors++; $display("FAIL rd_type: got %0d want 2", bus.dirTwoBack_Type); end
    checks++; if (bus.dirTwoBack_ChunkID !== 5'd1) begin errors++; $display("FAIL rd_chunk: got %0d want 1", bus.dirTwoBack_ChunkID); end
    checks++; if (bus.dirTwoBack_State !== 32'd3) begin errors++; $display("FAIL rd_state: got %0d want 3", bus.dirTwoBack_State); end
    checks++; if (bus.dirTwoBack_Last !== 1'b1) begin errors++; $display("FAIL rd_last: got %0d want 1", bus.dirTwoBack_Last); end
    checks++; if (bus.dirTwoBack_StreamID !== 4'd7 || bus.dirTwoBack_ChannelID !== 10'd0) begin
      errors++; $display("FAIL rd_ids: got sid %0d ch %0d want 7 0", bus.dirTwoBack_StreamID, bus.dirTwoBack_ChannelID); end
    checks++; if (bus.dirTwoBack_Data !== exp) begin errors++; $display("FAIL rd_data: got %h want %h", bus.dirTwoBack_Data, exp); end
    idle_all();
  endtask

  task automatic test_counters();
    @(negedge clk);
    bus.dirTwoBack_InstructionType = 2'd3;   // clear counters first
    @(negedge clk);
    bus.dirTwoBack_InstructionType = 2'd0;
    for (int i = 0; i < 7; i++) begin
      drv2(2'b01, 5'd0, 10'd0, 32'(i), {16{32'(i + 100)}}, 4'd1, (i == 6));
      @(negedge clk);
      if (i == 0) begin
        checks++; if (bus.dirTwoBack_Type !== 2'b01 || bus.dirTwoBack_Data !== {16{32'd100}}) begin
          errors++; $display("FAIL data_fwd: got type %0d data %h", bus.dirTwoBack_Type, bus.dirTwoBack_Data); end
      end
    end
    drv2(2'b10, c_REL_READ, 10'd0, 32'd16, '0, 4'd0, 1'b0);
    @(negedge clk);
    checks++; if (bus.dirTwoBack_Data !== {16{32'd7}}) begin errors++; $display("FAIL cnt_data: got %h want 7s", bus.dirTwoBack_Data); end
    drv2(2'b10, c_REL_READ, 10'd0, 32'd17, '0, 4'd0, 1'b0);
    @(negedge clk);
    checks++; if (bus.dirTwoBack_Data !== {16{32'd1}}) begin errors++; $display("FAIL cnt_consumed: got %h want 1s", bus.dirTwoBack_Data); end
    drv2(2'b10, c_REL_READ, 10'd0, 32'd40, '0, 4'd0, 1'b0);
    @(negedge clk);
    checks++; if (bus.dirTwoBack_Data !== '0 || bus.dirTwoBack_Type !== 2'b10 || bus.dirTwoBack_State !== 32'd40) begin
      errors++; $display("FAIL rd_oob: got type %0d state %0d data %h want 2 40 0", bus.dirTwoBack_Type, bus.dirTwoBack_State, bus.dirTwoBack_Data); end
    idle_all();
  endtask

  task automatic test_hop();
    logic [511:0] pat;
    pat = {16{32'h0BADBEEF}};
    @(negedge clk);
    drv2(2'b10, c_REL_READ, 10'd5, 32'd2, pat, 4'd3, 1'b1);
    @(negedge clk);
    checks++; if (bus.dirTwoBack_ChannelID !== 10'd4) begin errors++; $display("FAIL hop_ch: got %0d want 4", bus.dirTwoBack_ChannelID); end
    checks++; if (bus.dirTwoBack_Type !== 2'b10 || bus.dirTwoBack_ChunkID !== c_REL_READ || bus.dirTwoBack_State !== 32'd2
                  || bus.dirTwoBack_Data !== pat || bus.dirTwoBack_StreamID !== 4'd3) begin
      errors++; $display("FAIL hop_fields: got type %0d chunk %0d state %0d sid %0d", bus.dirTwoBack_Type,
                         bus.dirTwoBack_ChunkID, bus.dirTwoBack_State, bus.dirTwoBack_StreamID); end
    // Unknown opcode is dropped
    drv2(2'b10, c_REL_OP2, 10'd0, 32'd3, pat, 4'd3, 1'b1);
    @(negedge clk);
    checks++; if (bus.dirTwoBack_Type !== 2'b00) begin errors++; $display("FAIL drop_op: got %0d want 0", bus.dirTwoBack_Type); end
    // Write beyond the register file is ignored
    drv2(2'b10, c_REL_WRITE, 10'd0, 32'd16, {16{32'hFFFFFFFF}}, 4'd0, 1'b1);
    @(negedge clk);
    checks++; if (ctrl_regs !== '0 || bus.dirTwoBack_Type !== 2'b00) begin
      errors++; $display("FAIL wr_oob: got regs %h type %0d want 0 0", ctrl_regs, bus.dirTwoBack_Type); end
    // consumed: 3 reads earlier + op2 + oob write = 5; hop packet not counted
    drv2(2'b10, c_REL_READ, 10'd0, 32'd17, '0, 4'd0, 1'b0);
    @(negedge clk);
    checks++; if (bus.dirTwoBack_Data[31:0] !== 32'd5) begin errors++; $display("FAIL hop_consumed: got %0d want 5", bus.dirTwoBack_Data[31:0]); end
    idle_all();
  endtask

  task automatic test_instr_reset();
    @(negedge clk);
    drv2(2'b10, c_REL_WRITE, 10'd0, 32'd5, {480'd0, 32'h55}, 4'd0, 1'b1);
    @(negedge clk);
    checks++; if (ctrl_regs[191:160] !== 32'h55) begin errors++; $display("FAIL rst_pre: got %h want 55", ctrl_regs[191:160]); end
    drv2(2'b10, c_REL_WRITE, 10'd0, 32'd5, {480'd0, 32'h99}, 4'd0, 1'b1);
    bus.dirTwoBack_InstructionType = 2'd3;
    bus.dirTwoBack_InstructionParameter = 16'hA5A5;
    @(negedge clk);
    checks++; if (ctrl_regs !== '0) begin errors++; $display("FAIL rst_regs: got %h want 0", ctrl_regs); end
    checks++; if (bus.dirTwoFront_InstructionType !== 2'd0) begin errors++; $display("FAIL rst_fwd1: got %0d want 0", bus.dirTwoFront_InstructionType); end
    idle_all();
    @(negedge clk);
    checks++; if (bus.dirTwoFront_InstructionType !== 2'd0) begin errors++; $display("FAIL rst_fwd2: got %0d want 0", bus.dirTwoFront_InstructionType); end
    @(negedge clk);
    checks++; if (bus.dirTwoFront_InstructionType !== 2'd3 || bus.dirTwoFront_InstructionParameter !== 16'hA5A5) begin
      errors++; $display("FAIL rst_fwd3: got %0d/%h want 3/a5a5", bus.dirTwoFront_InstructionType, bus.dirTwoFront_InstructionParameter); end
    @(negedge clk);
    checks++; if (bus.dirTwoFront_InstructionType !== 2'd0) begin errors++; $display("FAIL rst_fwd4: got %0d want 0", bus.dirTwoFront_InstructionType); end
    drv2(2'b10, c_REL_READ, 10'd0, 32'd17, '0, 4'd0, 1'b0);
    @(negedge clk);
    checks++; if (bus.dirTwoBack_Data[31:0] !== 32'd0) begin errors++; $display("FAIL rst_ccnt: got %0d want 0", bus.dirTwoBack_Data[31:0]); end
    drv2(2'b10, c_REL_READ, 10'd0, 32'd16, '0, 4'd0, 1'b0);
    @(negedge clk);
    checks++; if (bus.dirTwoBack_Data[31:0] !== 32'd0) begin errors++; $display("FAIL rst_dcnt: got %0d want 0", bus.dirTwoBack_Data[31:0]); end
    idle_all();
  endtask

  task automatic test_passthrough();
    logic [511:0] p1;
    logic [511:0] p2;
    p1 = {16{32'h13572468}};
    p2 = {16{32'h600DF00D}};
    @(negedge clk);
    drv2(2'b10, 5'b00011, 10'd0, 32'h00000E05, p2, 4'd4, 1'b1);
    bus.dirOneFront_Data = p1; bus.dirOneFront_Type = 2'b01; bus.dirOneFront_Last = 1'b1;
    bus.dirOneFront_StreamID = 4'd9; bus.dirOneFront_ChunkID = 5'd3;
    bus.dirOneFront_ChannelID = 10'd700; bus.dirOneFront_State = 32'h12345678;
    bus.dirOneBack_InstructionType = 2'd1; bus.dirOneBack_InstructionStreamID = 4'd2;
    bus.dirOneBack_InstructionChannelID = 10'd5; bus.dirOneBack_InstructionParameter = 16'hBEEF;
    @(negedge clk);
    checks++; if (bus.dirTwoBack_Type !== 2'b10 || bus.dirTwoBack_ChunkID !== 5'b00011 || bus.dirTwoBack_ChannelID !== 10'd0
                  || bus.dirTwoBack_State !== 32'h00000E05 || bus.dirTwoBack_Data !== p2
                  || bus.dirTwoBack_StreamID !== 4'd4 || bus.dirTwoBack_Last !== 1'b1) begin
      errors++; $display("FAIL abs_fwd: got type %0d chunk %0d ch %0d state %h", bus.dirTwoBack_Type,
                         bus.dirTwoBack_ChunkID, bus.dirTwoBack_ChannelID, bus.dirTwoBack_State); end
    idle_all();
    checks++; if (bus.dirOneBack_Type !== 2'b00) begin errors++; $display("FAIL d1_early1: got %0d want 0", bus.dirOneBack_Type); end
    @(negedge clk);
    checks++; if (bus.dirOneBack_Type !== 2'b00) begin errors++; $display("FAIL d1_early2: got %0d want 0", bus.dirOneBack_Type); end
    @(negedge clk);
    checks++; if (bus.dirOneBack_Type !== 2'b01 || bus.dirOneBack_Data !== p1 || bus.dirOneBack_Last !== 1'b1
                  || bus.dirOneBack_StreamID !== 4'd9 || bus.dirOneBack_ChunkID !== 5'd3
                  || bus.dirOneBack_ChannelID !== 10'd700 || bus.dirOneBack_State !== 32'h12345678) begin
      errors++; $display("FAIL d1_fwd: got type %0d sid %0d chunk %0d ch %0d state %h", bus.dirOneBack_Type,
                         bus.dirOneBack_StreamID, bus.dirOneBack_ChunkID, bus.dirOneBack_ChannelID, bus.dirOneBack_State); end
    checks++; if (bus.dirOneFront_InstructionType !== 2'd1 || bus.dirOneFront_InstructionStreamID !== 4'd2
                  || bus.dirOneFront_InstructionChannelID !== 10'd5 || bus.dirOneFront_InstructionParameter !== 16'hBEEF) begin
      errors++; $display("FAIL i1_fwd: got %0d %0d %0d %h want 1 2 5 beef", bus.dirOneFront_InstructionType,
                         bus.dirOneFront_InstructionStreamID, bus.dirOneFront_InstructionChannelID,
                         bus.dirOneFront_InstructionParameter); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    drv2(2'b10, c_REL_WRITE, 10'd0, 32'd1, {480'd0, 32'h11}, 4'd0, 1'b1);
    @(negedge clk);
    checks++; if (ctrl_regs[63:32] !== 32'h11) begin errors++; $display("FAIL ar_pre: got %h want 11", ctrl_regs[63:32]); end
    for (int i = 0; i < 5; i++) begin
      drv2(2'b01, 5'd0, 10'd1, 32'(i), {16{32'(i)}}, 4'd1, 1'b0);
      bus.dirOneFront_Type = 2'b01; bus.dirOneFront_Data = {16{32'(i)}};
      bus.dirOneBack_InstructionType = 2'd1; bus.dirTwoBack_InstructionType = 2'd2;
      if (i < 4) @(negedge clk);
    end
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++; if (bus.dirOneBack_Type !== 2'b00 || bus.dirTwoBack_Type !== 2'b00) begin
      errors++; $display("FAIL ar_types: got %0d/%0d want 0/0", bus.dirOneBack_Type, bus.dirTwoBack_Type); end
    checks++; if (bus.dirOneFront_InstructionType !== 2'd0 || bus.dirTwoFront_InstructionType !== 2'd0) begin
      errors++; $display("FAIL ar_instr: got %0d/%0d want 0/0", bus.dirOneFront_InstructionType, bus.dirTwoFront_InstructionType); end
    idle_all();
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus.dirOneBack_Type !== 2'b00 || bus.dirTwoBack_Type !== 2'b00 || bus.dirOneFront_InstructionType !== 2'd0) begin
        errors++; $display("FAIL ar_replay%0d: got %0d/%0d/%0d want 0", i, bus.dirOneBack_Type, bus.dirTwoBack_Type,
                           bus.dirOneFront_InstructionType); end
    end
    checks++; if (ctrl_regs !== '0) begin errors++; $display("FAIL ar_regs: got %h want 0", ctrl_regs); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_read();
    test_counters();
    test_hop();
    test_instr_reset();
    test_passthrough();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
